mux_2x1_32b: RTL and testbench



---
 rtl/mux_2x1_32b.sv | 37 +++
 tb/tb_mux_2x1_32b.sv | 111 +++++++++++
 2 files changed

// File: rtl/mux_2x1_32b.sv
// mux_2x1_32b: registered word selector built from one-bit 2:1 mux cells (select=1 -> a, 0 -> b).
module mux_2x1_cell (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    logic s_n;
    assign s_n = ~s;
    assign y   = (s & a) | (s_n & b);
endmodule

module mux_2x1_32b #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             select,
    output logic [WIDTH-1:0] out
);
    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux_2x1_cell u_cell (
            .a(a[i]),
            .b(b[i]),
            .s(select),
            .y(sel_word[i])
        );
    end
    always_comb out_d = rst ? '0 : sel_word;
    always_ff @(posedge clk) out_q <= out_d;
    assign out = out_q;
endmodule

// File: tb/tb_mux_2x1_32b.sv
// tb_mux_2x1_32b: directed and randomized checks of mux_2x1_32b against a word-level model.
module tb_mux_2x1_32b;
    localparam int W = 32;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         select = 1'b0;
    logic [W-1:0] out;
    int           checks = 0;
    int           failures = 0;

    mux_2x1_32b #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .b(b),
        .select(select),
        .out(out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: the word present at the edge (or zero under reset) shows up just after it.
    task automatic tick(input string tag);
        logic [W-1:0] e;
        e = rst ? '0 : (select ? a : b);
        @(posedge clk);
        #1;
        check(tag, out, e);
    endtask

    task automatic drive(input logic r, input logic s, input logic [W-1:0] va, input logic [W-1:0] vb);
        rst = r;
        select = s;
        a = va;
        b = vb;
    endtask

    initial begin
        logic [W-1:0] held;
        @(negedge clk);
        drive(1, 1, 32'hFFFFFFFF, 32'h12345678);
        tick("reset");
        check("reset_zero", out, 32'h0);
        tick("reset_hold1");
        tick("reset_hold2");

        drive(0, 0, 32'hFFFFFFFF, 32'h12345678);
        tick("select_b");
        check("select_b_val", out, 32'h12345678);
        drive(0, 1, 32'h00000001, 32'hFFFFFFFF);
        tick("select_a_bit0");
        check("select_a_val", out, 32'h00000001);
        drive(0, 1, 32'h80000000, 32'h7FFFFFFF);
        tick("select_a_bit31");
        drive(0, 0, 32'h80000000, 32'h7FFFFFFF);
        tick("select_b_bit31");
        drive(0, 1, 32'h10000001, 32'h10000000);
        tick("near_eq_a");
        check("near_eq_a_val", out, 32'h10000001);
        drive(0, 0, 32'h10000001, 32'h10000000);
        tick("near_eq_b");
        check("near_eq_b_val", out, 32'h10000000);

        // Mid-cycle input changes must not disturb the held word.
        held = out;
        #2;
        drive(0, 1, 32'hDEADBEEF, 32'hCAFEF00D);
        #1;
        check("hold_mid_cycle", out, held);
        #2;
        select = 0;
        #1;
        check("hold_mid_cycle2", out, held);
        tick("latency_update");
        check("latency_val", out, 32'hCAFEF00D);

        // A reset pulse entirely between edges has no effect.
        drive(0, 0, 32'hFFFFFFFF, 32'h12345678);
        #1;
        rst = 1;
        #1;
        rst = 0;
        tick("rst_glitch_ignored");
        check("rst_glitch_val", out, 32'h12345678);

        drive(1, 0, 32'hFFFFFFFF, 32'h12345678);
        tick("midstream_reset");
        check("midstream_reset_val", out, 32'h0);
        rst = 0;
        tick("reset_recovery");
        check("reset_recovery_val", out, 32'h12345678);

        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 9) == 0), $urandom_range(0, 1), $urandom, $urandom);
            tick("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
